wb_arb: RTL and testbench

WB_ARB -- requirements
Module: wb_arb

---
 rtl/wb_arb_pkg.sv | 12 +
 rtl/wb_arb.sv | 129 ++++++++++++
 tb/tb_wb_arb.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the GPR write-port arbiter: FSM state encoding and
// the default MDU starvation limit.
package wb_arb_pkg;

  typedef enum logic [0:0] {
    S_PIPE  = 1'b0,
    S_FORCE = 1'b1
  } arb_state_e;

  localparam int STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/wb_arb.sv
// Arbitrates the single GPR write port between the pipeline W stage and the
// multi-cycle MDU, giving the pipeline priority until the MDU starves.
module wb_arb
  import wb_arb_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int GPR_SIZE   = 5,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_valid,
  input  logic [GPR_SIZE-1:0] wb_rd,
  input  logic [WIDTH-1:0]    wb_data,
  output logic                wb_allow_in,
  input  logic                mdu_valid,
  input  logic [GPR_SIZE-1:0] mdu_rd,
  input  logic [WIDTH-1:0]    mdu_data,
  output logic                mdu_ready,
  output logic                gpr_we,
  output logic [GPR_SIZE-1:0] gpr_waddr,
  output logic [WIDTH-1:0]    gpr_wdata,
  output logic                starve_flag
);

  localparam int               CNT_W      = $clog2(STARVE_MAX) + 1;
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  arb_state_e          state_r;
  arb_state_e          state_nxt_s;
  logic [CNT_W-1:0]    starve_cnt_r;
  logic [CNT_W-1:0]    starve_cnt_nxt_s;
  logic                wb_xfer_s;
  logic                mdu_xfer_s;

  // Handshake grants from the current state and the requester valids.
  always_comb begin
    wb_allow_in = 1'b1;
    mdu_ready   = 1'b0;
    case (state_r)
      S_PIPE: begin
        wb_allow_in = 1'b1;
        mdu_ready   = !wb_valid;
      end
      S_FORCE: begin
        wb_allow_in = !mdu_valid;
        mdu_ready   = 1'b1;
      end
      default: begin
        wb_allow_in = 1'b1;
        mdu_ready   = !wb_valid;
      end
    endcase
  end

  assign wb_xfer_s  = wb_valid && wb_allow_in;
  assign mdu_xfer_s = mdu_valid && mdu_ready;

  // Starvation count: grows on each denied MDU cycle, saturating at the limit.
  always_comb begin
    starve_cnt_nxt_s = starve_cnt_r;
    if (!mdu_valid || mdu_xfer_s) begin
      starve_cnt_nxt_s = {CNT_W{1'b0}};
    end else if (starve_cnt_r >= STARVE_LIM) begin
      starve_cnt_nxt_s = STARVE_LIM;
    end else begin
      starve_cnt_nxt_s = starve_cnt_r + CNT_ONE;
    end
  end

  // Next-state logic for the priority FSM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_PIPE: begin
        if (starve_cnt_nxt_s == STARVE_LIM) begin
          state_nxt_s = S_FORCE;
        end else begin
          state_nxt_s = S_PIPE;
        end
      end
      S_FORCE: begin
        // An MDU that drops valid while forced is tolerated: return without a write.
        if (mdu_xfer_s || !mdu_valid) begin
          state_nxt_s = S_PIPE;
        end else begin
          state_nxt_s = S_FORCE;
        end
      end
      default: begin
        state_nxt_s = S_PIPE;
      end
    endcase
  end

  // State, starvation counter and debug flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= S_PIPE;
      starve_cnt_r <= {CNT_W{1'b0}};
      starve_flag  <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      starve_cnt_r <= starve_cnt_nxt_s;
      starve_flag  <= (state_nxt_s == S_FORCE);
    end
  end

  // Registered GPR write port; rd 0 completes the handshake but never writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gpr_we    <= 1'b0;
      gpr_waddr <= {GPR_SIZE{1'b0}};
      gpr_wdata <= {WIDTH{1'b0}};
    end else if (mdu_xfer_s) begin
      gpr_we    <= (mdu_rd != {GPR_SIZE{1'b0}});
      gpr_waddr <= mdu_rd;
      gpr_wdata <= mdu_data;
    end else if (wb_xfer_s) begin
      gpr_we    <= (wb_rd != {GPR_SIZE{1'b0}});
      gpr_waddr <= wb_rd;
      gpr_wdata <= wb_data;
    end else begin
      gpr_we    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_arb.sv
// Directed self-checking bench for wb_arb: reset, pipeline streaming, lone MDU,
// rd 0, starvation forcing and reset in the middle of starvation.
module tb_wb_arb;

  localparam int WIDTH    = 64;
  localparam int GPR_SIZE = 5;

  logic                clk;
  logic                rst;
  logic                wb_valid;
  logic [GPR_SIZE-1:0] wb_rd;
  logic [WIDTH-1:0]    wb_data;
  logic                wb_allow_in;
  logic                mdu_valid;
  logic [GPR_SIZE-1:0] mdu_rd;
  logic [WIDTH-1:0]    mdu_data;
  logic                mdu_ready;
  logic                gpr_we;
  logic [GPR_SIZE-1:0] gpr_waddr;
  logic [WIDTH-1:0]    gpr_wdata;
  logic                starve_flag;

  int total = 0;
  int bad   = 0;

  wb_arb #(.WIDTH(WIDTH), .GPR_SIZE(GPR_SIZE), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_allow_in(wb_allow_in),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .gpr_we(gpr_we), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
    .starve_flag(starve_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 64'h1;
    mdu_valid = 1'b1; mdu_rd = 5'd4; mdu_data = 64'h2;
    #2;
    total++; if (wb_allow_in !== 1'b1) begin bad++; $display("FAIL rst_allow got=%b want=1", wb_allow_in); end
    total++; if (mdu_ready !== 1'b0) begin bad++; $display("FAIL rst_mdu_ready got=%b want=0", mdu_ready); end
    total++; if (gpr_we !== 1'b0 || gpr_waddr !== 5'd0 || gpr_wdata !== 64'd0) begin
      bad++; $display("FAIL rst_gpr got=%b/%0h/%0h want=0/0/0", gpr_we, gpr_waddr, gpr_wdata); end
    total++; if (starve_flag !== 1'b0) begin bad++; $display("FAIL rst_flag got=%b want=0", starve_flag); end
    wb_valid = 1'b0;
    #1;
    total++; if (mdu_ready !== 1'b1) begin bad++; $display("FAIL rst_mdu_ready_idle got=%b want=1", mdu_ready); end
    step(); step();
    total++; if (gpr_we !== 1'b0) begin bad++; $display("FAIL rst_no_write got=%b want=0", gpr_we); end
    mdu_valid = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_pipe_only();
    step();
    for (int i = 0; i < 8; i++) begin
      wb_valid = 1'b1; wb_rd = 5'(i + 1); wb_data = 64'h10 + 64'(i);
      #1;
      total++; if (wb_allow_in !== 1'b1) begin bad++; $display("FAIL pipe_allow[%0d] got=%b want=1", i, wb_allow_in); end
      if (i > 0) begin
        total++;
        if (gpr_we !== 1'b1 || gpr_waddr !== 5'(i) || gpr_wdata !== 64'h10 + 64'(i - 1)) begin
          bad++; $display("FAIL pipe_write[%0d] got=%b/%0h/%0h want=1/%0h/%0h",
                          i, gpr_we, gpr_waddr, gpr_wdata, i, 64'h10 + 64'(i - 1));
        end
      end
      step();
    end
    wb_valid = 1'b0;
    #1;
    total++; if (gpr_we !== 1'b1 || gpr_waddr !== 5'd8 || gpr_wdata !== 64'h17) begin
      bad++; $display("FAIL pipe_last got=%b/%0h/%0h want=1/8/17", gpr_we, gpr_waddr, gpr_wdata); end
    step();
    total++; if (gpr_we !== 1'b0 || gpr_waddr !== 5'd8 || gpr_wdata !== 64'h17) begin
      bad++; $display("FAIL pipe_idle_hold got=%b/%0h/%0h want=0/8/17", gpr_we, gpr_waddr, gpr_wdata); end
  endtask

  task automatic test_mdu_alone();
    wb_valid = 1'b0; mdu_valid = 1'b1; mdu_rd = 5'd5; mdu_data = 64'hDEAD;
    #1;
    total++; if (mdu_ready !== 1'b1) begin bad++; $display("FAIL mdu_ready got=%b want=1", mdu_ready); end
    step();
    mdu_valid = 1'b0;
    #1;
    total++; if (gpr_we !== 1'b1 || gpr_waddr !== 5'd5 || gpr_wdata !== 64'hDEAD) begin
      bad++; $display("FAIL mdu_write got=%b/%0h/%0h want=1/5/dead", gpr_we, gpr_waddr, gpr_wdata); end
    step();
  endtask

  task automatic test_rd_zero();
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 64'h55;
    #1;
    total++; if (wb_allow_in !== 1'b1) begin bad++; $display("FAIL rd0_allow got=%b want=1", wb_allow_in); end
    step();
    wb_valid = 1'b0;
    #1;
    total++; if (gpr_we !== 1'b0) begin bad++; $display("FAIL rd0_we got=%b want=0", gpr_we); end
    step();
  endtask

  task automatic test_starve();
    logic exp_force;
    mdu_rd = 5'd9; mdu_data = 64'hBEEF;
    for (int k = 0; k < 7; k++) begin
      exp_force = (k == 4);
      wb_valid = 1'b1; wb_rd = 5'(10 + k); wb_data = 64'h100 + 64'(k);
      mdu_valid = (k <= 4);
      #1;
      total++;
      if (starve_flag !== exp_force || wb_allow_in !== !exp_force || mdu_ready !== exp_force) begin
        bad++; $display("FAIL starve_hs[%0d] got=flag%b/allow%b/rdy%b want=flag%b/allow%b/rdy%b",
                        k, starve_flag, wb_allow_in, mdu_ready, exp_force, !exp_force, exp_force);
      end
      total++;
      if ((wb_valid && wb_allow_in) && (mdu_valid && mdu_ready)) begin
        bad++; $display("FAIL starve_dual_xfer[%0d] got=1 want=0", k);
      end
      if (k >= 1 && k != 5) begin
        total++;
        if (gpr_we !== 1'b1 || gpr_waddr !== 5'(10 + k - 1) || gpr_wdata !== 64'h100 + 64'(k - 1)) begin
          bad++; $display("FAIL starve_pipe_write[%0d] got=%b/%0h/%0h want=1/%0h/%0h",
                          k, gpr_we, gpr_waddr, gpr_wdata, 10 + k - 1, 64'h100 + 64'(k - 1));
        end
      end
      if (k == 5) begin
        total++;
        if (gpr_we !== 1'b1 || gpr_waddr !== 5'd9 || gpr_wdata !== 64'hBEEF) begin
          bad++; $display("FAIL starve_mdu_write got=%b/%0h/%0h want=1/9/beef", gpr_we, gpr_waddr, gpr_wdata);
        end
      end
      step();
    end
    wb_valid = 1'b0; mdu_valid = 1'b0;
    #1;
    total++; if (gpr_we !== 1'b1 || gpr_waddr !== 5'd16 || gpr_wdata !== 64'h106) begin
      bad++; $display("FAIL starve_resume got=%b/%0h/%0h want=1/10/106", gpr_we, gpr_waddr, gpr_wdata); end
    step();
  endtask

  task automatic test_reset_mid();
    logic exp_force;
    mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_data = 64'hCAFE;
    wb_valid = 1'b1; wb_rd = 5'd2; wb_data = 64'h22;
    step(); step(); step();
    rst = 1'b0;
    #1;
    total++; if (gpr_we !== 1'b0 || gpr_waddr !== 5'd0 || gpr_wdata !== 64'd0 || starve_flag !== 1'b0) begin
      bad++; $display("FAIL midrst_outputs got=%b/%0h/%0h/%b want=0/0/0/0", gpr_we, gpr_waddr, gpr_wdata, starve_flag); end
    total++; if (wb_allow_in !== 1'b1 || mdu_ready !== 1'b0) begin
      bad++; $display("FAIL midrst_hs got=%b/%b want=1/0", wb_allow_in, mdu_ready); end
    step();
    total++; if (gpr_we !== 1'b0) begin bad++; $display("FAIL midrst_no_write got=%b want=0", gpr_we); end
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_force = (k == 4);
      #1;
      total++;
      if (mdu_ready !== exp_force || starve_flag !== exp_force) begin
        bad++; $display("FAIL midrst_deny[%0d] got=rdy%b/flag%b want=rdy%b/flag%b",
                        k, mdu_ready, starve_flag, exp_force, exp_force);
      end
      step();
    end
    wb_valid = 1'b0; mdu_valid = 1'b0;
    #1;
    total++; if (gpr_we !== 1'b1 || gpr_waddr !== 5'd9 || gpr_wdata !== 64'hCAFE) begin
      bad++; $display("FAIL midrst_mdu_write got=%b/%0h/%0h want=1/9/cafe", gpr_we, gpr_waddr, gpr_wdata); end
    step();
    total++; if (gpr_we !== 1'b0 || starve_flag !== 1'b0) begin
      bad++; $display("FAIL midrst_idle got=%b/%b want=0/0", gpr_we, starve_flag); end
  endtask

  initial begin
    test_reset();
    test_pipe_only();
    test_mdu_alone();
    test_rd_zero();
    test_starve();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
